project_period_counter_gen2: RTL and testbench
==============================================

# project_period_counter_gen2

Parametrised successor to the PWM period counter master, for use as either timebase master or synchronised slave. It adds a configurable counter width, a clock prescaler, and a double-buffered (shadow) period register updated only at period boundaries. It also accepts an external sync input that phase-loads the counter, and exposes the count direction. It feeds the compare/duty units of the PWM peripheral and drives their sync chain.

## Interface
Parameters:
- WIDTH, 16, counter/period/compare width
- PRESCALE_W, 8, prescaler width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_en  in  1  counter enable
- i_mode  in  2  00 hold, 01 up, 10 down, 11 up-down
- i_period  in  WIDTH  period value for shadow register
- i_period_wr  in  1  strobe: shadow <= i_period
- i_prescale  in  PRESCALE_W  counter advances once every i_prescale+1 enabled clocks
- i_sync_en  in  1  enables o_sync generation
- i_sync_sel  in  2  o_sync source: 00 none, 01 count==0, 10 count==i_compare_b, 11 count==active period
- i_compare_b  in  WIDTH  compare value for sync source 10
- i_sync_in  in  1  external sync pulse (slave phase load)
- i_sync_in_en  in  1  enables i_sync_in
- i_phase  in  WIDTH  value loaded on accepted sync_in
- o_count  out  WIDTH  current count (register)
- o_count_next  out  WIDTH  value o_count takes at the next tick (combinational)
- o_dir  out  1  0 counting up, 1 counting down (register)
- o_period_active  out  WIDTH  active period register
- o_sync  out  1  one-clock sync pulse (register)

## Operation
- Reset: o_count=0, o_dir=0, shadow=0, o_period_active=0, prescaler=0, o_sync=0.
- Running = i_en && i_mode!=00. When not running, the following hold each cycle:
  - o_count and o_dir hold their values.
  - The prescaler clears.
  - o_period_active <= shadow.
  - o_sync=0.
- Prescaler: while running, increments each clock. When its value == i_prescale, the cycle is a tick and the prescaler returns to 0. With i_prescale=0, every running cycle is a tick.
- On a tick, o_count <= o_count_next. P = o_period_active, S = shadow.
  - Up: if count>=P, next=0, period event. Else next=count+1. o_dir=0.
  - Down: if count==0 or count>P, next=S, period event. Else next=count-1. o_dir=1.
  - Up-down, dir up: if count>=P, next=(P==0)?0:P-1 and dir<=1. Else next=count+1.
  - Up-down, dir down: if count==0, next=(S==0)?0:1, dir<=0, period event. Else next=count-1.
- Period event: o_period_active <= S in the same cycle. Period changes never take effect mid-period.
- i_period_wr: shadow updates the next cycle. A write in the cycle of a period event is not seen by that event.
- o_sync <= tick && i_sync_en && match(o_count_next), where match is selected by i_sync_sel. In up-down mode, source 10 fires on both slopes.
- Sync-in: accepted when i_sync_in && i_sync_in_en && running, and it has priority over a tick.
  - o_count <= min(i_phase, P) and the prescaler clears.
  - Up-down: if the loaded value == P, dir<=1; if 0, dir<=0; otherwise dir is unchanged.
  - No period event. o_sync is not asserted for the load.
- Mode changes take effect at the next tick. o_dir is set on the next tick (up mode forces 0, down mode forces 1).
- All arithmetic is modulo 2^WIDTH. Period 0 keeps the count at 0 in all modes.

## Timing
- Tick to o_count update: 1 clock. o_sync is high in the same cycle o_count first shows the matched value, for exactly one clock.
- o_count_next is valid combinationally in every cycle.
- Sync-in to o_count: 1 clock.
- Reset mid-operation returns every register to its reset value on the next edge, regardless of i_en.

## Test plan
- Enable gating: reset, write period 15, i_en=0, i_mode=01 for 16 clocks -> o_count stays 0 and o_period_active=15. Then set i_en=1 -> counts 1..15, 0, 1 on successive clocks.
- Modes at period 15, prescale 0:
  - Down from reset gives 15, 14..0, 15.
  - Up-down gives 1..15, 14..0, 1, with o_dir=1 exactly while descending.
- Prescaler: i_prescale=2, up mode -> o_count increments every 3 clocks. o_count_next equals the following o_count value.
- Shadow period: while running up with period 15, write 7 at count 5 -> count continues to 15, wraps to 0, then wraps at 7. o_period_active changes in the wrap cycle.
- Sync out: i_sync_sel=10, i_compare_b=5, up-down, period 15 -> one-clock o_sync pulses when o_count=5 on both slopes. With i_sync_en=0, no pulses.
- Sync in: i_phase=20, period 15, up-down, pulse i_sync_in mid-count -> o_count=15 next clock, o_dir=1, no o_sync. Asserting reset with the counter at 9 -> all outputs 0 next clock.

Source files
------------

// File: rtl/project_period_counter_gen2.sv
// ---------------------------------------------------------------------------
// project_period_counter_gen2
//
// PWM timebase counter that can act as a master or as a synchronised slave.
// It counts up, down or up-down against an active period register. That
// register is reloaded from a shadow copy only at period boundaries, so a
// period change never cuts a period short. A prescaler divides the count
// rate. An external sync pulse can phase-load the counter, and a selectable
// one-clock sync pulse is generated for downstream compare units.
//
// Parameters
//   WIDTH           counter / period / compare width
//   PRESCALE_W      prescaler width
//
// Ports
//   i_clk           clock, all state changes on the rising edge
//   i_reset         synchronous active-high reset
//   i_en            counter enable
//   i_mode          00 hold, 01 up, 10 down, 11 up-down
//   i_period        value written into the shadow period register
//   i_period_wr     shadow write strobe
//   i_prescale      counter advances once every i_prescale+1 running clocks
//   i_sync_en       enables o_sync generation
//   i_sync_sel      o_sync source: 00 none, 01 zero, 10 compare_b, 11 period
//   i_compare_b     compare value for sync source 10
//   i_sync_in       external sync pulse
//   i_sync_in_en    enables i_sync_in
//   i_phase         value loaded on an accepted sync-in (clamped to period)
//   o_count         current count
//   o_count_next    value o_count takes at the next tick (combinational)
//   o_dir           0 counting up, 1 counting down
//   o_period_active active period register
//   o_sync          one-clock sync pulse
// ---------------------------------------------------------------------------
module project_period_counter_gen2 #(
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_period,
  input  logic                  i_period_wr,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_sync_en,
  input  logic [1:0]            i_sync_sel,
  input  logic [WIDTH-1:0]      i_compare_b,
  input  logic                  i_sync_in,
  input  logic                  i_sync_in_en,
  input  logic [WIDTH-1:0]      i_phase,
  output logic [WIDTH-1:0]      o_count,
  output logic [WIDTH-1:0]      o_count_next,
  output logic                  o_dir,
  output logic [WIDTH-1:0]      o_period_active,
  output logic                  o_sync
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_UPDOWN = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    SYNC_NONE   = 2'b00,
    SYNC_ZERO   = 2'b01,
    SYNC_CMP    = 2'b10,
    SYNC_PERIOD = 2'b11
  } sync_sel_e;

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  mode_e                  mode;
  sync_sel_e              sync_sel;

  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       period_active_q;
  logic [WIDTH-1:0]       shadow_q;
  logic [PRESCALE_W-1:0]  prescale_q;
  logic                   dir_q;
  logic                   sync_q;

  logic                   running;
  logic                   tick;
  logic                   sync_accept;
  logic [WIDTH-1:0]       count_next;
  logic                   dir_next;
  logic                   period_event;
  logic                   sync_match;
  logic [WIDTH-1:0]       phase_load;

  assign mode     = mode_e'(i_mode);
  assign sync_sel = sync_sel_e'(i_sync_sel);

  assign running     = i_en && (mode != MODE_HOLD);
  assign tick        = running && (prescale_q == i_prescale);
  // A sync-in load wins over a tick landing in the same cycle.
  assign sync_accept = running && i_sync_in && i_sync_in_en;

  // Phase loads are clamped so a slave never sits outside its period.
  assign phase_load = (i_phase > period_active_q) ? period_active_q : i_phase;

  // Next-count rules. The comparisons use ">=" / ">" rather than "==" so a
  // counter left above a shrunken period (e.g. after a mode change) still
  // wraps instead of running off to 2^WIDTH.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_next   = count_q;
    dir_next     = dir_q;
    period_event = 1'b0;
    case (mode)
      MODE_UP: begin
        dir_next = 1'b0;
        if (count_q >= period_active_q) begin
          count_next   = '0;
          period_event = 1'b1;
        end else begin
          count_next = count_q + CNT_ONE;
        end
      end
      MODE_DOWN: begin
        dir_next = 1'b1;
        if (count_q == '0 || count_q > period_active_q) begin
          count_next   = shadow_q;
          period_event = 1'b1;
        end else begin
          count_next = count_q - CNT_ONE;
        end
      end
      MODE_UPDOWN: begin
        if (!dir_q) begin
          // Turn at the top without repeating the peak value.
          if (count_q >= period_active_q) begin
            count_next = (period_active_q == '0) ? '0 : period_active_q - CNT_ONE;
            dir_next   = 1'b1;
          end else begin
            count_next = count_q + CNT_ONE;
          end
        end else begin
          // The period boundary of a triangle is its valley.
          if (count_q == '0) begin
            count_next   = (shadow_q == '0) ? '0 : CNT_ONE;
            dir_next     = 1'b0;
            period_event = 1'b1;
          end else begin
            count_next = count_q - CNT_ONE;
          end
        end
      end
      default: begin
        count_next = count_q;
        dir_next   = dir_q;
      end
    endcase
  end

  always_comb begin
    sync_match = 1'b0;
    case (sync_sel)
      SYNC_ZERO:   sync_match = (count_next == '0);
      SYNC_CMP:    sync_match = (count_next == i_compare_b);
      SYNC_PERIOD: sync_match = (count_next == period_active_q);
      default:     sync_match = 1'b0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments and a synchronous reset,
  // so every register samples the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q         <= '0;
      dir_q           <= 1'b0;
      shadow_q        <= '0;
      period_active_q <= '0;
      prescale_q      <= '0;
      sync_q          <= 1'b0;
    end else begin
      if (i_period_wr) begin
        shadow_q <= i_period;
      end

      if (!running) begin
        // While stopped the period is free to follow the shadow, so a
        // fresh configuration is in force as soon as counting starts.
        prescale_q      <= '0;
        period_active_q <= shadow_q;
        sync_q          <= 1'b0;
      end else if (sync_accept) begin
        count_q    <= phase_load;
        prescale_q <= '0;
        sync_q     <= 1'b0;
        if (mode == MODE_UPDOWN) begin
          if (phase_load == period_active_q) begin
            dir_q <= 1'b1;
          end else if (phase_load == '0) begin
            dir_q <= 1'b0;
          end
        end
      end else if (tick) begin
        count_q    <= count_next;
        dir_q      <= dir_next;
        prescale_q <= '0;
        sync_q     <= i_sync_en && sync_match;
        if (period_event) begin
          period_active_q <= shadow_q;
        end
      end else begin
        prescale_q <= prescale_q + PRE_ONE;
        sync_q     <= 1'b0;
      end
    end
  end

  assign o_count         = count_q;
  assign o_count_next    = count_next;
  assign o_dir           = dir_q;
  assign o_period_active = period_active_q;
  assign o_sync          = sync_q;

endmodule

// File: tb/tb_project_period_counter_gen2.sv
module tb_project_period_counter_gen2;

  localparam int WIDTH      = 16;
  localparam int PRESCALE_W = 8;

  logic                  i_clk = 1'b0;
  logic                  i_reset;
  logic                  i_en;
  logic [1:0]            i_mode;
  logic [WIDTH-1:0]      i_period;
  logic                  i_period_wr;
  logic [PRESCALE_W-1:0] i_prescale;
  logic                  i_sync_en;
  logic [1:0]            i_sync_sel;
  logic [WIDTH-1:0]      i_compare_b;
  logic                  i_sync_in;
  logic                  i_sync_in_en;
  logic [WIDTH-1:0]      i_phase;
  logic [WIDTH-1:0]      o_count;
  logic [WIDTH-1:0]      o_count_next;
  logic                  o_dir;
  logic [WIDTH-1:0]      o_period_active;
  logic                  o_sync;

  always #5 i_clk = ~i_clk;

  project_period_counter_gen2 #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_en            (i_en),
    .i_mode          (i_mode),
    .i_period        (i_period),
    .i_period_wr     (i_period_wr),
    .i_prescale      (i_prescale),
    .i_sync_en       (i_sync_en),
    .i_sync_sel      (i_sync_sel),
    .i_compare_b     (i_compare_b),
    .i_sync_in       (i_sync_in),
    .i_sync_in_en    (i_sync_in_en),
    .i_phase         (i_phase),
    .o_count         (o_count),
    .o_count_next    (o_count_next),
    .o_dir           (o_dir),
    .o_period_active (o_period_active),
    .o_sync          (o_sync)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  int m_count, m_pa, m_shadow, m_pre;
  bit m_dir, m_sync;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Where the counter goes on its next tick, straight from the counting rules.
  function automatic void predict(input int c, input int p, input int s, input bit d,
                                  input logic [1:0] mode,
                                  output int nxt, output bit nd, output bit ev);
    nxt = c; nd = d; ev = 1'b0;
    case (mode)
      2'b01: begin
        nd = 1'b0;
        if (c >= p) begin nxt = 0; ev = 1'b1; end
        else nxt = c + 1;
      end
      2'b10: begin
        nd = 1'b1;
        if (c == 0 || c > p) begin nxt = s; ev = 1'b1; end
        else nxt = c - 1;
      end
      2'b11: begin
        if (!d) begin
          if (c >= p) begin nxt = (p == 0) ? 0 : p - 1; nd = 1'b1; end
          else nxt = c + 1;
        end else begin
          if (c == 0) begin nxt = (s == 0) ? 0 : 1; nd = 1'b0; ev = 1'b1; end
          else nxt = c - 1;
        end
      end
      default: ;
    endcase
  endfunction

  // One clock: the model follows the same inputs; chk enables comparisons.
  task automatic step(input bit chk);
    int nxt, lo;
    bit nd, ev, run, acc, tk, match;
    @(negedge i_clk);
    predict(m_count, m_pa, m_shadow, m_dir, i_mode, nxt, nd, ev);
    if (chk) check("count_next", 32'(o_count_next), 32'(nxt));
    run = i_en && (i_mode != 2'b00);
    acc = run && i_sync_in && i_sync_in_en;
    tk  = run && (m_pre == int'(i_prescale));
    case (i_sync_sel)
      2'b01:   match = (nxt == 0);
      2'b10:   match = (nxt == int'(i_compare_b));
      2'b11:   match = (nxt == m_pa);
      default: match = 1'b0;
    endcase
    lo = (int'(i_phase) < m_pa) ? int'(i_phase) : m_pa;
    @(posedge i_clk);
    if (i_reset) begin
      m_count = 0; m_dir = 0; m_shadow = 0; m_pa = 0; m_pre = 0; m_sync = 0;
    end else begin
      if (!run) begin
        m_pre = 0; m_pa = m_shadow; m_sync = 0;
      end else if (acc) begin
        m_count = lo; m_pre = 0; m_sync = 0;
        if (i_mode == 2'b11) begin
          if (lo == m_pa) m_dir = 1'b1;
          else if (lo == 0) m_dir = 1'b0;
        end
      end else if (tk) begin
        m_count = nxt; m_dir = nd; m_pre = 0;
        m_sync = i_sync_en && match;
        if (ev) m_pa = m_shadow;
      end else begin
        m_pre = (m_pre + 1) % 256;
        m_sync = 0;
      end
      if (i_period_wr) m_shadow = int'(i_period);
    end
    #1;
    if (chk) begin
      check("count", 32'(o_count), 32'(m_count));
      check("dir", 32'(o_dir), 32'(m_dir));
      check("period_active", 32'(o_period_active), 32'(m_pa));
      check("sync", 32'(o_sync), 32'(m_sync));
    end
  endtask

  task automatic idle();
    i_reset = 0; i_en = 0; i_mode = 0; i_period = 0; i_period_wr = 0;
    i_prescale = 0; i_sync_en = 0; i_sync_sel = 0; i_compare_b = 0;
    i_sync_in = 0; i_sync_in_en = 0; i_phase = 0;
  endtask

  // Reset, load the period while stopped, and leave it active.
  task automatic setup(input logic [1:0] mode, input int period, input int ps);
    idle();
    i_reset = 1; step(0);
    i_reset = 0; i_mode = mode; i_period = WIDTH'(period); i_period_wr = 1;
    i_prescale = PRESCALE_W'(ps); step(0);
    i_period_wr = 0; step(0);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         period;
    int         ps;
    int         cycles;
    int         exp_count;
    bit         exp_dir;
  } vec_t;

  vec_t vt[$];

  initial begin
    vt.push_back('{2'b01, 15, 0,  5,  5, 1'b0});
    vt.push_back('{2'b01, 15, 0, 16,  0, 1'b0});
    vt.push_back('{2'b01, 15, 0, 17,  1, 1'b0});
    vt.push_back('{2'b10, 15, 0,  1, 15, 1'b1});
    vt.push_back('{2'b10, 15, 0, 16,  0, 1'b1});
    vt.push_back('{2'b10, 15, 0, 17, 15, 1'b1});
    vt.push_back('{2'b11, 15, 0, 15, 15, 1'b0});
    vt.push_back('{2'b11, 15, 0, 16, 14, 1'b1});
    vt.push_back('{2'b11, 15, 0, 30,  0, 1'b1});
    vt.push_back('{2'b11, 15, 0, 31,  1, 1'b0});
    vt.push_back('{2'b01, 15, 2,  8,  2, 1'b0});
    vt.push_back('{2'b01, 15, 2,  9,  3, 1'b0});
    vt.push_back('{2'b01,  0, 0, 10,  0, 1'b0});
    vt.push_back('{2'b10,  0, 0,  5,  0, 1'b1});
    vt.push_back('{2'b11,  0, 0,  5,  0, 1'b1});

    m_count = 0; m_pa = 0; m_shadow = 0; m_pre = 0; m_dir = 0; m_sync = 0;

    // Reset state.
    idle();
    i_reset = 1; step(0);
    i_reset = 0;
    check("reset count", 32'(o_count), 0);
    check("reset dir", 32'(o_dir), 0);
    check("reset period_active", 32'(o_period_active), 0);
    check("reset sync", 32'(o_sync), 0);
    check("reset count_next", 32'(o_count_next), 0);

    // Table: run N clocks from reset at a given mode/period/prescale.
    foreach (vt[i]) begin
      setup(vt[i].mode, vt[i].period, vt[i].ps);
      i_en = 1;
      repeat (vt[i].cycles) step(0);
      check($sformatf("vec%0d count", i), 32'(o_count), 32'(vt[i].exp_count));
      check($sformatf("vec%0d dir", i), 32'(o_dir), 32'(vt[i].exp_dir));
    end

    // Enable gating.
    idle();
    i_reset = 1; step(0);
    i_reset = 0; i_mode = 2'b01; i_period = 15; i_period_wr = 1; step(0);
    i_period_wr = 0;
    repeat (15) step(0);
    check("gated count", 32'(o_count), 0);
    check("gated period_active", 32'(o_period_active), 15);
    i_en = 1;
    for (int k = 1; k <= 17; k++) begin
      step(0);
      check("enabled count", 32'(o_count), 32'(k % 16));
    end

    // Prescaler, with count_next compared every cycle by the model.
    setup(2'b01, 15, 2);
    i_en = 1;
    for (int t = 1; t <= 9; t++) begin
      step(1);
      check("prescaled count", 32'(o_count), 32'(t / 3));
    end

    // Shadow period written mid-period.
    setup(2'b01, 15, 0);
    i_en = 1;
    repeat (5) step(0);
    check("shadow pre count", 32'(o_count), 5);
    i_period = 7; i_period_wr = 1; step(0);
    i_period_wr = 0;
    check("shadow write count", 32'(o_count), 6);
    for (int k = 7; k <= 15; k++) begin
      step(0);
      check("shadow old count", 32'(o_count), 32'(k));
      check("shadow old period", 32'(o_period_active), 15);
    end
    step(0);
    check("shadow wrap count", 32'(o_count), 0);
    check("shadow wrap period", 32'(o_period_active), 7);
    for (int k = 1; k <= 7; k++) begin
      step(0);
      check("shadow new count", 32'(o_count), 32'(k));
    end
    step(0);
    check("shadow new wrap", 32'(o_count), 0);

    // Sync out on compare_b, both slopes of the triangle.
    setup(2'b11, 15, 0);
    i_sync_en = 1; i_sync_sel = 2'b10; i_compare_b = 5; i_en = 1;
    for (int t = 1; t <= 31; t++) begin
      step(0);
      check("tri count", 32'(o_count), 32'((t <= 15) ? t : ((t <= 30) ? 30 - t : 1)));
      check("tri dir", 32'(o_dir), 32'(t >= 16 && t <= 30));
      check("tri sync", 32'(o_sync), 32'(t == 5 || t == 25));
    end
    i_sync_en = 0;
    for (int t = 1; t <= 30; t++) begin
      step(0);
      check("sync disabled", 32'(o_sync), 0);
    end

    // Sync in clamps to the period, turns the triangle, no sync pulse.
    setup(2'b11, 15, 0);
    i_sync_en = 1; i_sync_sel = 2'b11; i_en = 1;
    repeat (4) step(0);
    check("sync_in pre count", 32'(o_count), 4);
    i_phase = 20; i_sync_in = 1; i_sync_in_en = 1; step(0);
    i_sync_in = 0;
    check("sync_in count", 32'(o_count), 15);
    check("sync_in dir", 32'(o_dir), 1);
    check("sync_in sync", 32'(o_sync), 0);
    step(0);
    check("sync_in after", 32'(o_count), 14);
    repeat (5) step(0);
    check("pre reset count", 32'(o_count), 9);
    i_reset = 1; step(0);
    i_reset = 0;
    check("midrun reset count", 32'(o_count), 0);
    check("midrun reset dir", 32'(o_dir), 0);
    check("midrun reset period", 32'(o_period_active), 0);
    check("midrun reset sync", 32'(o_sync), 0);

    // Randomised run against the model.
    idle();
    i_reset = 1; step(0);
    i_reset = 0;
    for (int n = 0; n < 3000; n++) begin
      i_reset      = ($urandom_range(0, 199) == 0);
      i_en         = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) i_mode = 2'($urandom_range(0, 3));
      i_period_wr  = ($urandom_range(0, 19) == 0);
      i_period     = WIDTH'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) i_prescale = PRESCALE_W'($urandom_range(0, 3));
      i_sync_en    = ($urandom_range(0, 3) != 0);
      i_sync_sel   = 2'($urandom_range(0, 3));
      i_compare_b  = WIDTH'($urandom_range(0, 20));
      i_sync_in    = ($urandom_range(0, 29) == 0);
      i_sync_in_en = ($urandom_range(0, 1) == 1);
      i_phase      = WIDTH'($urandom_range(0, 25));
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
